// File: rtl/maquina_ctrl_n_if.sv
// Control/status bundle of the FIFO-monitoring controller.
// The master side drives requests, thresholds and FIFO flags and observes
// the latched thresholds and status; the slave side is the controller itself.
interface maquina_ctrl_n_if #(
    parameter int N_FIFOS  = 5,
    parameter int N_CLASES = 3,
    parameter int UW       = 5,
    parameter int CNT_W    = 4
);
    logic                      init;
    logic                      err_clr;
    logic [N_CLASES*UW-1:0]    umbral_alto;
    logic [N_CLASES*UW-1:0]    umbral_bajo;
    logic [N_FIFOS-1:0]        fifo_empties;
    logic [N_FIFOS-1:0]        fifo_errors;

    logic [N_CLASES*UW-1:0]    umbral_alto_int;
    logic [N_CLASES*UW-1:0]    umbral_bajo_int;
    logic                      idle_out;
    logic                      active_out;
    logic                      error_out;
    logic [N_FIFOS-1:0]        errors_out;
    logic                      cfg_err;
    logic [CNT_W-1:0]          err_count;
    logic [2:0]                state_out;

    modport master (
        output init, err_clr, umbral_alto, umbral_bajo, fifo_empties, fifo_errors,
        input  umbral_alto_int, umbral_bajo_int, idle_out, active_out, error_out,
               errors_out, cfg_err, err_count, state_out
    );

    modport slave (
        input  init, err_clr, umbral_alto, umbral_bajo, fifo_empties, fifo_errors,
        output umbral_alto_int, umbral_bajo_int, idle_out, active_out, error_out,
               errors_out, cfg_err, err_count, state_out
    );
endinterface

// File: rtl/maquina_ctrl_n.sv
// FIFO-monitoring controller: latches per-class thresholds, tracks whether
// the monitored FIFOs are idle or active, and traps FIFO or threshold faults
// in an ERROR state with a sticky error vector and a saturating entry count.
//
// state  | meaning
// RESET  | one-cycle start-up state after reset
// INIT   | thresholds loaded every cycle; validated on exit
// IDLE   | all FIFOs empty
// ACTIVE | some FIFO non-empty, or waiting out the idle delay
// ERROR  | FIFO error or bad thresholds; waits for err_clr with no errors
module maquina_ctrl_n #(
    parameter int N_FIFOS  = 5,
    parameter int N_CLASES = 3,
    parameter int UW       = 5,
    parameter int IDLE_DLY = 1,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    maquina_ctrl_n_if.slave   bus
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    // 8 bits covers the full 1..255 idle-delay range; the counter never
    // passes IDLE_DLY-1 because reaching it forces the move to IDLE.
    localparam logic [7:0] DLY_LAST = 8'(IDLE_DLY - 1);

    state_t                   state;
    logic [N_CLASES*UW-1:0]   alto_q;
    logic [N_CLASES*UW-1:0]   bajo_q;
    logic [7:0]               dly_cnt;
    logic [N_FIFOS-1:0]       err_vec;
    logic                     cfg_q;
    logic [CNT_W-1:0]         cnt_q;

    logic                     cfg_bad;
    logic                     any_err;
    logic                     all_empty;
    logic [CNT_W-1:0]         cnt_inc;

    // Threshold sanity check on the values being loaded this cycle.
    always_comb begin
        cfg_bad = 1'b0;
        for (int k = 0; k < N_CLASES; k++) begin
            if (bus.umbral_alto[k*UW +: UW] < bus.umbral_bajo[k*UW +: UW]) begin
                cfg_bad = 1'b1;
            end
        end
    end

    assign any_err   = |bus.fifo_errors;
    assign all_empty = &bus.fifo_empties;
    assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    // Main sequencer: state, thresholds, idle delay and error bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_RESET;
            alto_q  <= '0;
            bajo_q  <= '0;
            dly_cnt <= '0;
            err_vec <= '0;
            cfg_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state)
                S_RESET: begin
                    state <= S_INIT;
                end
                S_INIT: begin
                    alto_q <= bus.umbral_alto;
                    bajo_q <= bus.umbral_bajo;
                    if (!bus.init) begin
                        if (cfg_bad) begin
                            state   <= S_ERROR;
                            err_vec <= bus.fifo_errors;
                            cfg_q   <= 1'b1;
                            cnt_q   <= cnt_inc;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_IDLE: begin
                    if (bus.init) begin
                        state <= S_INIT;
                    end else if (any_err) begin
                        state   <= S_ERROR;
                        err_vec <= bus.fifo_errors;
                        cnt_q   <= cnt_inc;
                    end else if (!all_empty) begin
                        state   <= S_ACTIVE;
                        dly_cnt <= '0;
                    end
                end
                S_ACTIVE: begin
                    if (bus.init) begin
                        state <= S_INIT;
                    end else if (any_err) begin
                        state   <= S_ERROR;
                        err_vec <= bus.fifo_errors;
                        cnt_q   <= cnt_inc;
                    end else if (!all_empty) begin
                        dly_cnt <= '0;
                    end else if (dly_cnt == DLY_LAST) begin
                        state   <= S_IDLE;
                        dly_cnt <= '0;
                    end else begin
                        dly_cnt <= dly_cnt + 8'd1;
                    end
                end
                S_ERROR: begin
                    if (bus.err_clr && !any_err) begin
                        state   <= S_INIT;
                        err_vec <= '0;
                        cfg_q   <= 1'b0;
                    end else begin
                        err_vec <= err_vec | bus.fifo_errors;
                    end
                end
                default: begin
                    state <= S_RESET;
                end
            endcase
        end
    end

    assign bus.umbral_alto_int = alto_q;
    assign bus.umbral_bajo_int = bajo_q;
    assign bus.idle_out        = (state == S_IDLE);
    assign bus.active_out      = (state == S_ACTIVE);
    assign bus.error_out       = (state == S_ERROR);
    assign bus.state_out       = state;
    assign bus.errors_out      = err_vec;
    assign bus.cfg_err         = cfg_q;
    assign bus.err_count       = cnt_q;

endmodule

// File: doc/maquina_ctrl_n.md
MAQUINA_CTRL_N -- requirements
Module: maquina_ctrl_n

Interface
REQ-001 Parameter N_FIFOS, default 5, number of monitored FIFOs.
REQ-002 Parameter N_CLASES, default 3, number of threshold classes (MF, VC, D ordering at default).
REQ-003 Parameter UW, default 5, threshold width in bits.
REQ-004 Parameter IDLE_DLY, default 1, consecutive all-empty cycles required for ACTIVE->IDLE; legal range 1..255.
REQ-005 Parameter CNT_W, default 4, width of the error-entry counter.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-low.
REQ-008 init  in  1  request (re)load of thresholds.
REQ-009 err_clr  in  1  request exit from ERROR.
REQ-010 umbral_alto  in  N_CLASES*UW  high thresholds; class k at bits [k*UW +: UW].
REQ-011 umbral_bajo  in  N_CLASES*UW  low thresholds, same packing.
REQ-012 fifo_empties  in  N_FIFOS  per-FIFO empty flags.
REQ-013 fifo_errors  in  N_FIFOS  per-FIFO error flags.
REQ-014 umbral_alto_int  out  N_CLASES*UW  latched high thresholds.
REQ-015 umbral_bajo_int  out  N_CLASES*UW  latched low thresholds.
REQ-016 idle_out, active_out, error_out  out  1 each  state flags.
REQ-017 errors_out  out  N_FIFOS  sticky FIFO error vector.
REQ-018 cfg_err  out  1  invalid threshold configuration.
REQ-019 err_count  out  CNT_W  saturating count of ERROR entries.
REQ-020 state_out  out  3  encoding RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.

Function
REQ-021 States RESET, INIT, IDLE, ACTIVE, ERROR; any other encoding goes to RESET on the next edge.
REQ-022 RESET -> INIT unconditionally after one cycle.
REQ-023 INIT: every cycle, umbral_*_int load umbral_* inputs; otherwise they hold.
REQ-024 INIT exit, when init=0: if any class has alto < bajo (unsigned) -> ERROR with cfg_err set; otherwise -> IDLE. init=1 keeps INIT.
REQ-025 IDLE transition priority: init=1 -> INIT; else fifo_errors != 0 -> ERROR; else fifo_empties != all-ones -> ACTIVE; else stay.
REQ-026 ACTIVE priority: init=1 -> INIT; else fifo_errors != 0 -> ERROR; else IDLE after IDLE_DLY consecutive cycles with fifo_empties all-ones.
REQ-027 Idle-delay counter: cleared on ACTIVE entry and on any cycle with a non-empty FIFO; increments only in ACTIVE; no overflow possible before transition.
REQ-028 ERROR exit only when err_clr=1 AND fifo_errors=0 -> INIT; init ignored in ERROR.
REQ-029 idle_out, active_out, error_out, state_out: pure decode of state register, one-hot among the three flags, no combinational input-to-output path.
REQ-030 errors_out: loads fifo_errors on the edge entering ERROR, ORs in fifo_errors each ERROR cycle, clears to 0 on the edge leaving ERROR.
REQ-031 cfg_err: set on INIT->ERROR threshold-fault edge, held during ERROR, cleared on leaving ERROR; FIFO-caused ERROR leaves cfg_err=0.
REQ-032 err_count increments by 1 on every edge entering ERROR, saturates at 2^CNT_W-1, cleared only by reset.
REQ-033 Simultaneous init=1 and fifo_errors!=0 in IDLE/ACTIVE: init wins.

Reset
REQ-034 reset=0 at an edge, in any state, forces state RESET and clears all outputs, internal thresholds, idle-delay counter, errors_out, cfg_err and err_count to 0.
REQ-035 Reset mid-ERROR or mid-INIT discards partial state; restart follows REQ-022.

Verification (N_FIFOS=5, N_CLASES=3, UW=5, IDLE_DLY=4, CNT_W=4)
REQ-036 Reset release, init=0, alto=5'd20 each, bajo=5'd4 each -> state_out 0,1,2 on consecutive cycles; umbral_alto_int=all 20; idle_out=1.
REQ-037 In IDLE, fifo_empties=5'b11101 for 3 cycles then 5'b11111 -> ACTIVE next cycle; IDLE exactly 4 cycles after empties return; a single non-empty cycle mid-count restarts the 4-cycle wait.
REQ-038 In ACTIVE, fifo_errors=5'b00100 one cycle then 5'b01000 one cycle -> ERROR, errors_out=5'b00100 then 5'b01100, err_count=1; err_clr=1 with errors 0 -> INIT, errors_out=0.
REQ-039 Class 1 alto=3, bajo=9, init pulse -> INIT then ERROR, cfg_err=1, errors_out=0; init in ERROR ignored.
REQ-040 18 ERROR entries -> err_count stops at 15; reset=0 in ACTIVE -> all outputs 0 next cycle.
